lsu_axi_master: RTL
===================

LSU_AXI_MASTER -- requirements
Module: lsu_axi_master

Interface
REQ-001 TIMEOUT_CYCLES, default 255: response wait limit in cycles; used only when AXI_TIMEOUT_EN is defined.
REQ-002 clock  input  1  clock; all logic on the rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  1 / req_ready  output  1: core request handshake.
REQ-005 req_wen in 1 (1 = write), req_addr in 32, req_size in 3, req_wdata in 64, req_wstrb in 8: request payload.
REQ-006 resp_valid out 1, resp_rdata out 64, resp_err out 1: one-cycle response pulse to core.
REQ-007 AR: axi_arid out 4, axi_arlen out 8, axi_arsize out 3, axi_arburst out 2, axi_araddr out 32, axi_arvalid out 1, axi_arready in 1.
REQ-008 R: axi_rdata in 64, axi_rresp in 2, axi_rvalid in 1, axi_rlast in 1, axi_rid in 4, axi_rready out 1.
REQ-009 AW: axi_awid out 4, axi_awlen out 8, axi_awsize out 3, axi_awburst out 2, axi_awaddr out 32, axi_awvalid out 1, axi_awready in 1.
REQ-010 W: axi_wdata out 64, axi_wstrb out 8, axi_wvalid out 1, axi_wlast out 1, axi_wready in 1.
REQ-011 B: axi_bid in 4, axi_bresp in 2, axi_bvalid in 1, axi_bready out 1.

Function
REQ-012 FSM states: IDLE, RADDR, RDATA, WREQ, WRESP, DONE; exactly one outstanding transaction.
REQ-013 req_ready = 1 only in IDLE; on req_valid & req_ready, latch the payload and go to RADDR (req_wen = 0) or WREQ (req_wen = 1).
REQ-014 Fixed fields: arid/awid = 0, arlen/awlen = 0, arburst/awburst = 2'b01, wlast = 1; arsize/awsize = latched req_size.
REQ-015 Addresses, wdata and wstrb come from the latched payload and stay stable while their valid is high.
REQ-016 RADDR: arvalid = 1 and held until arready; the cycle after the handshake, go to RDATA with arvalid = 0.
REQ-017 RDATA: rready = 1; on rvalid, capture rdata and set err = (rresp != 0), then go to DONE; rid and rlast are ignored.
REQ-018 WREQ: awvalid and wvalid both rise on entry; each drops the cycle after its own handshake (tracked in aw_done and w_done); go to WRESP once both are done, including when both handshake in the same cycle.
REQ-019 WRESP: bready = 1; on bvalid, set err = (bresp != 0), then go to DONE; bid is ignored.
REQ-020 DONE: resp_valid = 1 for exactly one cycle, with resp_rdata = captured data (0 for writes) and resp_err = err; then go to IDLE.
REQ-021 Latency with a zero-wait slave: accept at cycle N, arvalid at N+1, rready at N+2, resp_valid at N+3; writes have the same latency.
REQ-022 No AXI valid depends combinationally on any ready; all AXI outputs are registered or decoded from state.
REQ-023 Misaligned addresses are not checked and are passed through unchanged.

Reset
REQ-024 While reset is asserted: state = IDLE; req_ready, arvalid, awvalid, wvalid, rready, bready, resp_valid and resp_err = 0; resp_rdata and latched payload = 0.
REQ-025 req_ready = 1 in the first cycle after reset deasserts.
REQ-026 Reset during any state abandons the transaction and produces no response; the slave must be reset in the same cycle.

Configuration
REQ-027 With AXI_TIMEOUT_EN defined: a wait counter clears on entry to RADDR or WREQ and increments every cycle in RADDR, RDATA, WREQ or WRESP.
REQ-028 With AXI_TIMEOUT_EN defined: when the counter reaches TIMEOUT_CYCLES, drop all AXI valid/ready outputs and go to DONE with resp_err = 1 and resp_rdata = 0.
REQ-029 With AXI_TIMEOUT_EN defined: a late R or B beat after a timeout is not accepted (rready = bready = 0 in IDLE).
REQ-030 Without AXI_TIMEOUT_EN: no counter logic exists and the block waits indefinitely.

Verification
REQ-031 Read 0xa0000048, size 2; slave returns rdata 0x1234, rresp 0 with zero wait -> resp_valid at accept+3, rdata 0x1234, err 0.
REQ-032 Write 0x80000000, wdata 0xdeadbeef, wstrb 0x0f; awready 3 cycles before wready -> awvalid drops first, wvalid holds until accepted, single resp_valid, err 0.
REQ-033 Read with rresp = 2'b01 and random 0-15 cycle slave delays -> resp_err = 1; arvalid never deasserts before arready.
REQ-034 reset asserted in RDATA -> next cycle all valids are 0, no resp_valid, and req_ready = 1 after reset releases.
REQ-035 AXI_TIMEOUT_EN defined, TIMEOUT_CYCLES = 8, slave never responds -> resp_valid with err 1 exactly 8 cycles after entering RADDR.

Source files
------------

// File: rtl/lsu_axi_master.sv
// lsu_axi_master: bridges the core load/store port to AXI4 with one transaction in flight.
// Define AXI_TIMEOUT_EN to abandon a transaction after TIMEOUT_CYCLES cycles of waiting.
module lsu_axi_master #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clock,
   input  logic        reset,

   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [31:0] req_addr,
   input  logic [2:0]  req_size,
   input  logic [63:0] req_wdata,
   input  logic [7:0]  req_wstrb,

   output logic        resp_valid,
   output logic [63:0] resp_rdata,
   output logic        resp_err,

   output logic [3:0]  axi_arid,
   output logic [7:0]  axi_arlen,
   output logic [2:0]  axi_arsize,
   output logic [1:0]  axi_arburst,
   output logic [31:0] axi_araddr,
   output logic        axi_arvalid,
   input  logic        axi_arready,

   input  logic [63:0] axi_rdata,
   input  logic [1:0]  axi_rresp,
   input  logic        axi_rvalid,
   input  logic        axi_rlast,
   input  logic [3:0]  axi_rid,
   output logic        axi_rready,

   output logic [3:0]  axi_awid,
   output logic [7:0]  axi_awlen,
   output logic [2:0]  axi_awsize,
   output logic [1:0]  axi_awburst,
   output logic [31:0] axi_awaddr,
   output logic        axi_awvalid,
   input  logic        axi_awready,

   output logic [63:0] axi_wdata,
   output logic [7:0]  axi_wstrb,
   output logic        axi_wvalid,
   output logic        axi_wlast,
   input  logic        axi_wready,

   input  logic [3:0]  axi_bid,
   input  logic [1:0]  axi_bresp,
   input  logic        axi_bvalid,
   output logic        axi_bready
);

   typedef enum logic [2:0] {IDLE, RADDR, RDATA, WREQ, WRESP, DONE} state_e;

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [2:0]  size_q, size_d;
   logic [63:0] wdata_q, wdata_d;
   logic [7:0]  wstrb_q, wstrb_d;
   logic [63:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic        aw_done_q, aw_done_d;
   logic        w_done_q, w_done_d;

`ifdef AXI_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`endif

   // IDs and last flags carry no information with a single outstanding single-beat transfer.
   logic unused_ok;
   assign unused_ok = ^{axi_rid, axi_rlast, axi_bid};

   // State and payload registers with synchronous active-high reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         size_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
`ifdef AXI_TIMEOUT_EN
         wait_cnt_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         size_q    <= size_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
`ifdef AXI_TIMEOUT_EN
         wait_cnt_q <= wait_cnt_d;
`endif
      end
   end

   // Next-state logic: walks one transaction through the AXI channels.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      size_d    = size_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
`ifdef AXI_TIMEOUT_EN
      wait_cnt_d = wait_cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d    = req_addr;
               size_d    = req_size;
               wdata_d   = req_wdata;
               wstrb_d   = req_wstrb;
               rdata_d   = '0;
               err_d     = 1'b0;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = req_wen ? WREQ : RADDR;
            end
         end
         RADDR: begin
            if (axi_arready) state_d = RDATA;
         end
         RDATA: begin
            if (axi_rvalid) begin
               rdata_d = axi_rdata;
               err_d   = (axi_rresp != 2'b00);
               state_d = DONE;
            end
         end
         WREQ: begin
            // A channel still pending has its valid high, so its ready alone marks the handshake.
            aw_done_d = aw_done_q | axi_awready;
            w_done_d  = w_done_q | axi_wready;
            if (aw_done_d && w_done_d) state_d = WRESP;
         end
         WRESP: begin
            if (axi_bvalid) begin
               err_d   = (axi_bresp != 2'b00);
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
`ifdef AXI_TIMEOUT_EN
      // The budget spans the whole transaction; a handshake landing on the last cycle still wins.
      if (state_q inside {RADDR, RDATA, WREQ, WRESP}) begin
         wait_cnt_d = wait_cnt_q + 1'b1;
         if (state_d == state_q && wait_cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_d = DONE;
            err_d   = 1'b1;
            rdata_d = '0;
         end
      end
      if (state_q == IDLE && req_valid) wait_cnt_d = '0;
`endif
   end

   // Output decode: every valid/ready is derived from registered state only.
   always_comb begin
      req_ready   = 1'b0;
      axi_arvalid = 1'b0;
      axi_rready  = 1'b0;
      axi_awvalid = 1'b0;
      axi_wvalid  = 1'b0;
      axi_bready  = 1'b0;
      resp_valid  = 1'b0;
      resp_err    = 1'b0;
      resp_rdata  = '0;
      case (state_q)
         IDLE:  req_ready = !reset;
         RADDR: axi_arvalid = 1'b1;
         RDATA: axi_rready = 1'b1;
         WREQ: begin
            axi_awvalid = !aw_done_q;
            axi_wvalid  = !w_done_q;
         end
         WRESP: axi_bready = 1'b1;
         DONE: begin
            resp_valid = 1'b1;
            resp_err   = err_q;
            resp_rdata = rdata_q;
         end
         default: begin
            req_ready = 1'b0;
         end
      endcase
   end

   assign axi_arid    = 4'd0;
   assign axi_arlen   = 8'd0;
   assign axi_arburst = 2'b01;
   assign axi_arsize  = size_q;
   assign axi_araddr  = addr_q;

   assign axi_awid    = 4'd0;
   assign axi_awlen   = 8'd0;
   assign axi_awburst = 2'b01;
   assign axi_awsize  = size_q;
   assign axi_awaddr  = addr_q;

   assign axi_wdata   = wdata_q;
   assign axi_wstrb   = wstrb_q;
   assign axi_wlast   = 1'b1;

endmodule
